iter_mult_sew: RTL and testbench
================================

// Module: iter_mult_sew
// PURPOSE
//  Parametrised iterative multiplier for the execution unit. It multiplies two operands of
//  selectable element width (SEW) by sequencing DIGIT_W x DIGIT_W partial products through
//  one internal unsigned digit multiplier and accumulating them, shifted, into a 2*MAX_W register.
//  Adds signed/unsigned mode, runtime width selection, a valid/ready handshake on both sides,
//  and a synchronous flush. Sits between operand decode and the execution-unit writeback mux.
// PARAMETERS
//  MAX_W    32  maximum operand width; must equal DIGIT_W * 2^k
//  DIGIT_W   8  digit width of the internal multiplier
//  SEW_W     2  width of the sew field; element width = DIGIT_W << sew, clamped to MAX_W
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-low reset
//  flush      in   1        synchronous abort of any in-flight operation
//  in_valid   in   1        operands valid
//  in_ready   out  1        block accepts operands (high only in IDLE)
//  sew        in   SEW_W    element width select; 0=8, 1=16, 2=32 at defaults; above max clamps to MAX_W
//  is_signed  in   1        1 = two's-complement operands, 0 = unsigned
//  op_a       in   MAX_W    multiplicand; only the low SEW bits are used
//  op_b       in   MAX_W    multiplier; only the low SEW bits are used
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  result     out  2*MAX_W  full 2*SEW-bit product, sign-extended (signed) or zero-extended to 2*MAX_W
// BEHAVIOUR
//  Reset (reset low): state=IDLE, accumulator=0, result=0, out_valid=0, in_ready=1, all
//   counters=0. Reset takes effect immediately, including mid-operation.
//  Accept: in_valid & in_ready at a rising edge latches sew, is_signed, op_a and op_b. N = SEW/DIGIT_W.
//  State machine:
//   IDLE : in_ready=1. On accept, go to PREP.
//   PREP : mask operands to SEW bits. If signed, take the magnitude of each operand and
//          record neg = sign_a ^ sign_b. Clear the accumulator. Go to MUL.
//   MUL  : N*N cycles. Cycle (i,j) with i = a-digit index (inner loop) and j = b-digit index
//          (outer loop): acc += (a_i * b_j) << (DIGIT_W*(i+j)). The order matches the existing
//          32-bit unit: A0B0, A1B0, ... A(N-1)B0, A0B1, ... After the last digit, go to FIX.
//   FIX  : take the low 2*SEW bits of acc. If neg, negate them. Sign-extend (signed) or
//          zero-extend (unsigned) to 2*MAX_W and register as result. Go to DONE.
//   DONE : out_valid=1. On out_ready, go to IDLE.
//  Latency: out_valid rises N*N+2 cycles after the accept edge (8-bit: 3, 16-bit: 6, 32-bit: 18).
//  Backpressure: while out_valid & !out_ready, result and out_valid hold stable and in_ready=0.
//   There is no back-to-back accept in DONE.
//  Flush: from any state, the next state is IDLE, out_valid=0, and the accumulator is cleared.
//   If flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
//  Arithmetic: the accumulator is 2*MAX_W+1 bits wide. The carry out of the 2*SEW bits is discarded.
//   Signed -2^(SEW-1) is handled by its magnitude 2^(SEW-1), which fits unsigned in SEW bits.
//  sew and is_signed are sampled only at accept. Changes on these inputs mid-operation are ignored.
// TESTING
//  T1 unsigned sew=2, a=b=0xFFFFFFFF -> result=0xFFFFFFFE00000001; out_valid at edge 18 after accept.
//  T2 signed sew=0, a=0x80, b=0xFF -> result=0x0000000000000080 after 3 cycles.
//     Repeat with a=0xAAAAAA80 to confirm upper bits are ignored: same result.
//  T3 signed sew=1, a=0x8000, b=0x0002 -> result=0xFFFFFFFFFFFF0000 after 6 cycles.
//     The same operands unsigned -> result=0x0000000000010000.
//  T4 backpressure: T1 with out_ready=0 for 5 cycles after out_valid -> result, out_valid=1 and
//     in_ready=0 stable. out_ready=1 -> IDLE next cycle.
//  T5 flush on MUL cycle 7 of a sew=2 operation -> IDLE next edge, out_valid never rises.
//     A following signed 3 x -5 at sew=0 -> result=0xFFFFFFFFFFFFFFF1.
//  T6 reset low in MUL, asynchronous to clk -> result=0, out_valid=0, in_ready=1 before the next
//     edge. Release, then T1 completes correctly.

Source files
------------

// File: rtl/iter_mult_sew.sv
// Iterative signed/unsigned multiplier with runtime element width.
// Products are built from DIGIT_W x DIGIT_W partial products that are added into a wide accumulator.
module iter_mult_sew #(
    parameter int MAX_W   = 32,
    parameter int DIGIT_W = 8,
    parameter int SEW_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEW_W-1:0]   sew,
    input  logic               is_signed,
    input  logic [MAX_W-1:0]   op_a,
    input  logic [MAX_W-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*MAX_W-1:0] result
);
    localparam int NDIG    = MAX_W / DIGIT_W;
    localparam int MAX_LOG = $clog2(NDIG);
    localparam int CNT_W   = (MAX_LOG > 0) ? MAX_LOG : 1;
    localparam int PW      = 2 * MAX_W;
    localparam int ACC_W   = PW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state;
    logic [SEW_W-1:0]   sew_q;
    logic               signed_q;
    logic               neg_q;
    logic [MAX_W-1:0]   a_q;
    logic [MAX_W-1:0]   b_q;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   i_cnt;
    logic [CNT_W-1:0]   j_cnt;
    logic [PW-1:0]      result_q;

    logic               accept;
    logic [SEW_W-1:0]   sew_cl;
    logic [31:0]        ew;
    logic [31:0]        two_ew;
    logic [MAX_W-1:0]   mask_w;
    logic [MAX_W-1:0]   a_m;
    logic [MAX_W-1:0]   b_m;
    logic               sign_a;
    logic               sign_b;
    logic [MAX_W-1:0]   mag_a;
    logic [MAX_W-1:0]   mag_b;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [2*DIGIT_W-1:0] prod;
    int                 sh;
    logic [ACC_W-1:0]   acc_add;
    logic [CNT_W-1:0]   last_cnt;
    logic [PW-1:0]      mask_p;
    logic [PW-1:0]      p_lo;
    logic [PW-1:0]      p_neg;
    logic [PW-1:0]      p_sel;
    logic               p_top;
    logic [PW-1:0]      p_fix;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        sew_cl = (int'(sew) > MAX_LOG) ? SEW_W'(MAX_LOG) : sew;
    end

    // Operand conditioning: mask to element width, then magnitude when signed.
    always_comb begin
        ew     = 32'(DIGIT_W) << sew_q;
        two_ew = ew << 1;
        mask_w = {MAX_W{1'b1}} >> (32'(MAX_W) - ew);
        a_m    = a_q & mask_w;
        b_m    = b_q & mask_w;
        sign_a = signed_q && 1'(a_m >> (ew - 32'd1));
        sign_b = signed_q && 1'(b_m >> (ew - 32'd1));
        mag_a  = sign_a ? ((~a_m + MAX_W'(1)) & mask_w) : a_m;
        mag_b  = sign_b ? ((~b_m + MAX_W'(1)) & mask_w) : b_m;
    end

    always_comb begin
        a_dig    = DIGIT_W'(a_q >> (DIGIT_W * int'(i_cnt)));
        b_dig    = DIGIT_W'(b_q >> (DIGIT_W * int'(j_cnt)));
        prod     = {{DIGIT_W{1'b0}}, a_dig} * {{DIGIT_W{1'b0}}, b_dig};
        sh       = DIGIT_W * (int'(i_cnt) + int'(j_cnt));
        acc_add  = acc + (ACC_W'(prod) << sh);
        last_cnt = CNT_W'((32'd1 << sew_q) - 32'd1);
    end

    // Carry beyond 2*SEW is dropped by the mask before the optional negate and extension.
    always_comb begin
        mask_p = {PW{1'b1}} >> (32'(PW) - two_ew);
        p_lo   = acc[PW-1:0] & mask_p;
        p_neg  = (~p_lo + PW'(1)) & mask_p;
        p_sel  = neg_q ? p_neg : p_lo;
        p_top  = 1'(p_sel >> (two_ew - 32'd1));
        p_fix  = (signed_q && p_top) ? (p_sel | ~mask_p) : p_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            sew_q    <= '0;
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sew_q    <= sew_cl;
                        signed_q <= is_signed;
                        a_q      <= op_a;
                        b_q      <= op_b;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    a_q   <= mag_a;
                    b_q   <= mag_b;
                    neg_q <= sign_a ^ sign_b;
                    acc   <= '0;
                    i_cnt <= '0;
                    j_cnt <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    acc <= acc_add;
                    if (i_cnt == last_cnt) begin
                        i_cnt <= '0;
                        if (j_cnt == last_cnt) begin
                            j_cnt <= '0;
                            state <= S_FIX;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    result_q <= p_fix;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_mult_sew.sv
// Directed bench for iter_mult_sew: latency, signed/unsigned products, backpressure, flush and async reset.
module tb_iter_mult_sew;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sew;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;
    logic seen_valid;

    iter_mult_sew #(.MAX_W(32), .DIGIT_W(8), .SEW_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sew       (sew),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation, measures accept-to-out_valid latency, optionally holds out_ready low.
    task automatic run_op(input string tag, input logic [1:0] s, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] exp, input int hold);
        int n;
        @(negedge clk);
        sew = s; is_signed = sg; op_a = a; op_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        sew = ~s; is_signed = ~sg; op_a = ~a; op_b = ~b;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_result"}, result, exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_result"}, result, exp);
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; sew = 2'd0; is_signed = 1'b0;
        op_a = '0; op_b = '0; out_ready = 1'b1;
        #2;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // T1
        run_op("t1", 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 64'hFFFF_FFFE_0000_0001, 0);
        // T2
        run_op("t2", 2'd0, 1'b1, 32'h0000_0080, 32'h0000_00FF, 3, 64'h0000_0000_0000_0080, 0);
        run_op("t2_hi", 2'd0, 1'b1, 32'hAAAA_AA80, 32'h0000_00FF, 3, 64'h0000_0000_0000_0080, 0);
        // T3
        run_op("t3_s", 2'd1, 1'b1, 32'h0000_8000, 32'h0000_0002, 6, 64'hFFFF_FFFF_FFFF_0000, 0);
        run_op("t3_u", 2'd1, 1'b0, 32'h0000_8000, 32'h0000_0002, 6, 64'h0000_0000_0001_0000, 0);
        // sew above the maximum clamps to 32-bit
        run_op("clamp", 2'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 64'hFFFF_FFFE_0000_0001, 0);
        // signed 32-bit: -1 * -1 and most-negative squared
        run_op("s32_m1", 2'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 64'h0000_0000_0000_0001, 0);
        run_op("s32_min", 2'd2, 1'b1, 32'h8000_0000, 32'h8000_0000, 18, 64'h4000_0000_0000_0000, 0);
        run_op("u16", 2'd1, 1'b0, 32'h0000_1234, 32'h0000_5678, 6, 64'h0000_0000_0626_0060, 0);
        // T4
        run_op("t4", 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 64'hFFFF_FFFE_0000_0001, 5);

        // T5: flush lands on MUL cycle 7 (edge 8 after accept)
        seen_valid = 1'b0;
        @(negedge clk);
        sew = 2'd2; is_signed = 1'b0; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1 if (out_valid) seen_valid = 1'b1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_flush_ready", 64'(in_ready), 64'd1);
        chk("t5_flush_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_flush_wins", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (out_valid) seen_valid = 1'b1;
        end
        chk("t5_no_valid", 64'(seen_valid), 64'd0);
        run_op("t5_after", 2'd0, 1'b1, 32'h0000_0003, 32'h0000_00FB, 3, 64'hFFFF_FFFF_FFFF_FFF1, 0);

        // T6: asynchronous reset mid-MUL
        @(negedge clk);
        sew = 2'd2; is_signed = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t6_result", result, 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        run_op("t6_t1", 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 64'hFFFF_FFFE_0000_0001, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
